// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bit pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, redirect flush and EX forwarding selects
// Ports:
//   clk, rst_n                  pipeline clock, asynchronous active-low reset
//   id_*                        decoded control bundle and register indices from the ID stage
//   ex_branch_taken             EX-stage branch outcome from the datapath comparator
//   stall, flush                combinational hazard controls for PC/IF/ID/ID-EX
//   ex_*, mem_*, wb_*           registered control bundles of the EX, MEM and WB stages
//   fwd_a, fwd_b                EX operand selects: 00 regfile, 10 from MEM, 01 from WB
//   stall_cnt, flush_cnt        saturating event counters
module ctrl_pipe #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_is_jal,
    input  logic [1:0]        id_branch,
    input  logic [1:0]        id_alu_op,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_alu_src,
    output logic              ex_mem_write,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_is_jal,
    output logic [1:0]        ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_write,
    output logic              mem_mem_read,
    output logic              mem_mem_to_reg,
    output logic [4:0]        mem_rd,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);
    logic bubble;
    logic ld;
    assign flush  = ex_valid & (ex_branch_taken | ex_is_jal);
    // a redirect squashes the load-use pair anyway, so flush masks stall
    assign stall  = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush;
    assign bubble = flush | stall;
    // controls enter EX only for a real, non-squashed instruction
    assign ld     = ~bubble & id_valid;
    assign fwd_a  = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                    (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == ex_rs1) ? 2'b01 : 2'b00;
    assign fwd_b  = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                    (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == ex_rs2) ? 2'b01 : 2'b00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_is_jal      <= 1'b0;
            ex_branch      <= 2'b00;
            ex_alu_op      <= 2'b00;
            ex_rs1         <= 5'd0;
            ex_rs2         <= 5'd0;
            ex_rd          <= 5'd0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_rd         <= 5'd0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_rd          <= 5'd0;
            stall_cnt      <= '0;
            flush_cnt      <= '0;
        end else begin
            ex_valid       <= ld;
            ex_reg_write   <= ld & id_reg_write;
            ex_alu_src     <= ld & id_alu_src;
            ex_mem_write   <= ld & id_mem_write;
            ex_mem_read    <= ld & id_mem_read;
            ex_mem_to_reg  <= ld & id_mem_to_reg;
            ex_is_jal      <= ld & id_is_jal;
            ex_branch      <= ld ? id_branch : 2'b00;
            ex_alu_op      <= ld ? id_alu_op : 2'b00;
            ex_rs1         <= bubble ? 5'd0 : id_rs1;
            ex_rs2         <= bubble ? 5'd0 : id_rs2;
            ex_rd          <= bubble ? 5'd0 : id_rd;
            mem_reg_write  <= ex_valid & ex_reg_write;
            // jal bundles arrive with mem_write set by the decoder
            mem_mem_write  <= ex_valid & ex_mem_write & ~ex_is_jal;
            mem_mem_read   <= ex_valid & ex_mem_read;
            mem_mem_to_reg <= ex_valid & ex_mem_to_reg;
            mem_rd         <= ex_rd;
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_rd          <= mem_rd;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + STAT_W'(1);
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized and directed checks of ctrl_pipe against a stage-record reference model
module tb_ctrl_pipe;
    localparam int SW = 2;
    typedef struct packed {
        logic v, rw, as, mw, mr, mtr, jal;
        logic [1:0] br, op;
        logic [4:0] rs1, rs2, rd;
    } bun_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ex_taken = 1'b0;
    bun_t id_b = '0;
    logic stall, flush, ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_is_jal;
    logic [1:0] ex_branch, ex_alu_op, fwd_a, fwd_b;
    logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg, wb_reg_write, wb_mem_to_reg;
    logic [SW-1:0] stall_cnt, flush_cnt;
    bun_t d_ex;
    bun_t m_ex, m_mem, m_wb;
    logic [SW-1:0] m_sc, m_fc;
    int vecs = 0;
    int errs = 0;
    always #5 clk = ~clk;
    assign d_ex = {ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_is_jal,
                   ex_branch, ex_alu_op, ex_rs1, ex_rs2, ex_rd};
    ctrl_pipe #(.STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_b.v), .id_reg_write(id_b.rw), .id_alu_src(id_b.as),
        .id_mem_write(id_b.mw), .id_mem_read(id_b.mr), .id_mem_to_reg(id_b.mtr), .id_is_jal(id_b.jal),
        .id_branch(id_b.br), .id_alu_op(id_b.op), .id_rs1(id_b.rs1), .id_rs2(id_b.rs2), .id_rd(id_b.rd),
        .ex_branch_taken(ex_taken), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_is_jal(ex_is_jal),
        .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    function automatic bun_t mk(input logic [6:0] c, input logic [1:0] br, input logic [1:0] op,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {c, br, op, rs1, rs2, rd};
    endfunction
    function automatic bun_t i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(7'b1100000, 2'b00, 2'b10, rs1, rs2, rd);
    endfunction
    function automatic bun_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return mk(7'b1110110, 2'b00, 2'b00, rs1, 5'd0, rd);
    endfunction
    function automatic bun_t i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(7'b1000000, 2'b01, 2'b01, rs1, rs2, 5'd0);
    endfunction
    function automatic bun_t i_jal(input logic [4:0] rd);
        return mk(7'b1101001, 2'b00, 2'b00, 5'd0, 5'd0, rd);
    endfunction
    function automatic logic m_flush();
        return m_ex.v && (ex_taken || m_ex.jal);
    endfunction
    function automatic logic m_stall();
        return id_b.v && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
               (m_ex.rd == id_b.rs1 || m_ex.rd == id_b.rs2) && !m_flush();
    endfunction
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction
    task automatic mdl_step();
        bun_t nx, nm;
        logic f, s;
        f = m_flush();
        s = m_stall();
        if (s && m_sc != '1) m_sc = m_sc + 1'b1;
        if (f && m_fc != '1) m_fc = m_fc + 1'b1;
        nm = '0;
        nm.rw = m_ex.v & m_ex.rw;
        nm.mw = m_ex.v & m_ex.mw & ~m_ex.jal;
        nm.mr = m_ex.v & m_ex.mr;
        nm.mtr = m_ex.v & m_ex.mtr;
        nm.rd = m_ex.rd;
        nx = '0;
        if (!(f || s)) begin
            nx.rs1 = id_b.rs1;
            nx.rs2 = id_b.rs2;
            nx.rd = id_b.rd;
            if (id_b.v) nx = id_b;
        end
        m_wb = m_mem;
        m_mem = nm;
        m_ex = nx;
    endtask
    task automatic tick();
        @(posedge clk);
        mdl_step();
        #1;
    endtask
    task automatic reset_dut();
        logic [31:0] r;
        @(negedge clk);
        r = $urandom;
        rst_n = 1'b0;
        id_b = r[25:0];
        ex_taken = r[31];
        m_ex = '0;
        m_mem = '0;
        m_wb = '0;
        m_sc = '0;
        m_fc = '0;
        #2;
    endtask
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        id_b = '0;
        ex_taken = 1'b0;
    endtask
    task automatic test_reset();
        reset_dut();
        vecs++;
        if ({d_ex, mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg, mem_rd,
             wb_reg_write, wb_mem_to_reg, wb_rd} !== '0) begin
            errs++;
            $display("FAIL reset_regs got ex=%h mem_rd=%h wb_rd=%h exp all 0", d_ex, mem_rd, wb_rd);
        end
        vecs++;
        if ({stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt} !== '0) begin
            errs++;
            $display("FAIL reset_comb got %b exp 0", {stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt});
        end
        release_rst();
        id_b = i_add(5'd5, 5'd1, 5'd2);
        tick();
        id_b = '0;
        vecs++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd5}) begin
            errs++;
            $display("FAIL reset_lat1 got v=%b rd=%0d exp v=1 rd=5", ex_valid, ex_rd);
        end
        tick();
        vecs++;
        if ({mem_reg_write, mem_rd} !== {1'b1, 5'd5}) begin
            errs++;
            $display("FAIL reset_lat2 got rw=%b rd=%0d exp rw=1 rd=5", mem_reg_write, mem_rd);
        end
        tick();
        vecs++;
        if ({wb_reg_write, wb_rd} !== {1'b1, 5'd5}) begin
            errs++;
            $display("FAIL reset_lat3 got rw=%b rd=%0d exp rw=1 rd=5", wb_reg_write, wb_rd);
        end
    endtask
    task automatic test_load_use();
        reset_dut();
        release_rst();
        id_b = i_lw(5'd3, 5'd0);
        tick();
        id_b = i_add(5'd4, 5'd3, 5'd2);
        #1;
        vecs++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL lu_stall got %b exp 1", stall);
        end
        tick();
        vecs++;
        if ({ex_valid, stall, stall_cnt} !== {1'b0, 1'b0, 2'd1}) begin
            errs++;
            $display("FAIL lu_bubble got v=%b stall=%b cnt=%0d exp v=0 stall=0 cnt=1", ex_valid, stall, stall_cnt);
        end
        tick();
        id_b = '0;
        vecs++;
        if ({ex_valid, ex_rd, fwd_a, fwd_b, wb_mem_to_reg, stall_cnt} !== {1'b1, 5'd4, 2'b01, 2'b00, 1'b1, 2'd1}) begin
            errs++;
            $display("FAIL lu_fwd got v=%b rd=%0d fa=%b fb=%b mtr=%b cnt=%0d exp 1 4 01 00 1 1",
                     ex_valid, ex_rd, fwd_a, fwd_b, wb_mem_to_reg, stall_cnt);
        end
    endtask
    task automatic test_forward();
        logic [3:0] exp_f [3] = '{4'b1010, 4'b0101, 4'b0000};
        logic [4:0] r;
        for (int k = 0; k < 3; k++) begin
            reset_dut();
            release_rst();
            r = (k == 2) ? 5'd0 : 5'd1;
            id_b = i_add(r, 5'd2, 5'd3);
            tick();
            id_b = (k == 1) ? bun_t'('0) : i_add(r, 5'd4, 5'd5);
            tick();
            id_b = i_add(5'd6, r, r);
            tick();
            id_b = '0;
            vecs++;
            if ({fwd_a, fwd_b} !== exp_f[k]) begin
                errs++;
                $display("FAIL fwd_case%0d got %b exp %b", k, {fwd_a, fwd_b}, exp_f[k]);
            end
        end
    endtask
    task automatic test_branch();
        reset_dut();
        release_rst();
        id_b = i_beq(5'd1, 5'd2);
        tick();
        ex_taken = 1'b1;
        id_b = i_add(5'd7, 5'd1, 5'd1);
        #1;
        vecs++;
        if (flush !== 1'b1) begin
            errs++;
            $display("FAIL br_flush got %b exp 1", flush);
        end
        tick();
        ex_taken = 1'b0;
        vecs++;
        if ({ex_valid, flush_cnt} !== {1'b0, 2'd1}) begin
            errs++;
            $display("FAIL br_squash got v=%b cnt=%0d exp v=0 cnt=1", ex_valid, flush_cnt);
        end
        id_b = i_lw(5'd3, 5'd0);
        tick();
        id_b = i_add(5'd4, 5'd3, 5'd0);
        ex_taken = 1'b1;
        #1;
        vecs++;
        if ({flush, stall} !== 2'b10) begin
            errs++;
            $display("FAIL br_prio got flush=%b stall=%b exp 1 0", flush, stall);
        end
        tick();
        ex_taken = 1'b0;
        id_b = '0;
        vecs++;
        if ({ex_valid, stall_cnt, flush_cnt} !== {1'b0, 2'd0, 2'd2}) begin
            errs++;
            $display("FAIL br_prio_cnt got v=%b sc=%0d fc=%0d exp 0 0 2", ex_valid, stall_cnt, flush_cnt);
        end
    endtask
    task automatic test_jal();
        reset_dut();
        release_rst();
        id_b = i_jal(5'd1);
        tick();
        id_b = '0;
        #1;
        vecs++;
        if (flush !== 1'b1) begin
            errs++;
            $display("FAIL jal_flush got %b exp 1", flush);
        end
        tick();
        vecs++;
        if ({mem_mem_write, mem_reg_write, mem_rd, ex_valid} !== {1'b0, 1'b1, 5'd1, 1'b0}) begin
            errs++;
            $display("FAIL jal_mem got mw=%b rw=%b rd=%0d exv=%b exp 0 1 1 0", mem_mem_write, mem_reg_write, mem_rd, ex_valid);
        end
    endtask
    task automatic test_saturation();
        reset_dut();
        release_rst();
        id_b = i_lw(5'd3, 5'd3);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                vecs++;
                if (stall_cnt !== 2'd1) begin
                    errs++;
                    $display("FAIL sat_first got %0d exp 1", stall_cnt);
                end
            end
        end
        id_b = '0;
        vecs++;
        if (stall_cnt !== 2'd3) begin
            errs++;
            $display("FAIL sat_hold got %0d exp 3", stall_cnt);
        end
    endtask
    task automatic test_random();
        logic [31:0] r;
        reset_dut();
        release_rst();
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            id_b = r[25:0];
            id_b.v = ($urandom_range(0, 3) != 0);
            id_b.rs1 = 5'($urandom_range(0, 3));
            id_b.rs2 = 5'($urandom_range(0, 3));
            id_b.rd = 5'($urandom_range(0, 3));
            ex_taken = ($urandom_range(0, 7) == 0);
            #1;
            vecs++;
            if ({stall, flush, fwd_a, fwd_b} !== {m_stall(), m_flush(), m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)}) begin
                errs++;
                $display("FAIL rnd_comb cyc%0d got %b exp %b", i, {stall, flush, fwd_a, fwd_b},
                         {m_stall(), m_flush(), m_fwd(m_ex.rs1), m_fwd(m_ex.rs2)});
            end
            tick();
            vecs++;
            if (d_ex !== m_ex) begin
                errs++;
                $display("FAIL rnd_ex cyc%0d got %h exp %h", i, d_ex, m_ex);
            end
            vecs++;
            if ({mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg, mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd} !==
                {m_mem.rw, m_mem.mw, m_mem.mr, m_mem.mtr, m_mem.rd, m_wb.rw, m_wb.mtr, m_wb.rd}) begin
                errs++;
                $display("FAIL rnd_memwb cyc%0d got %b exp %b", i,
                         {mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg, mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd},
                         {m_mem.rw, m_mem.mw, m_mem.mr, m_mem.mtr, m_mem.rd, m_wb.rw, m_wb.mtr, m_wb.rd});
            end
            vecs++;
            if ({stall_cnt, flush_cnt} !== {m_sc, m_fc}) begin
                errs++;
                $display("FAIL rnd_cnt cyc%0d got sc=%0d fc=%0d exp sc=%0d fc=%0d", i, stall_cnt, flush_cnt, m_sc, m_fc);
            end
        end
    endtask
    initial begin
        m_ex = '0;
        m_mem = '0;
        m_wb = '0;
        m_sc = '0;
        m_fc = '0;
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_jal();
        test_saturation();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
